// File: rtl/div_flotante_seq_if.sv
// Handshake/data bundle for the sequential float divider.
//   master : operand source (drives i_valid and both operands, sees results)
//   slave  : divider side (drives o_ready, o_cociente, o_valid and flags)
// Float format: {sign, exp[NB_EXP], man[NB_MAN]}, hidden 1, biased exponent.
interface div_flotante_seq_if #(
    parameter int NB_EXP = 4,
    parameter int NB_MAN = 8
);
    localparam int NB_FLT = 1 + NB_EXP + NB_MAN;

    logic              i_valid;
    logic              o_ready;
    logic [NB_FLT-1:0] i_flotante_1;
    logic [NB_FLT-1:0] i_flotante_2;
    logic [NB_FLT-1:0] o_cociente;
    logic              o_valid;
    logic              o_div_cero;
    logic              o_desborde;

    modport master (
        output i_valid, i_flotante_1, i_flotante_2,
        input  o_ready, o_cociente, o_valid, o_div_cero, o_desborde
    );

    modport slave (
        input  i_valid, i_flotante_1, i_flotante_2,
        output o_ready, o_cociente, o_valid, o_div_cero, o_desborde
    );
endinterface

// File: rtl/div_flotante_seq.sv
// Sequential divider for the custom float format {sign, exp, man}, hidden 1,
// biased exponent: o_cociente = i_flotante_1 / i_flotante_2.
// Restoring mantissa division, one quotient bit per clock.
//
// Ports:
//   i_clock  : system clock, rising edge
//   i_reset  : synchronous active-high reset; aborts an operation in flight
//   bus      : div_flotante_seq_if.slave
//              i_valid/o_ready      operand handshake (accept when both high)
//              i_flotante_1/_2      dividend / divisor
//              o_cociente           quotient, held until next result
//              o_valid              1-cycle pulse when o_cociente/flags update
//              o_div_cero           divisor was zero
//              o_desborde           exponent overflow, result saturated
//
// Build option: define DIV_FLOTANTE_REDONDEO_EN for round-half-up using the
// guard bit; otherwise the quotient mantissa is truncated.
//
// state | meaning
// IDLE  | o_ready=1, waiting for i_valid
// CALC  | one restoring-division step per clock, NB_MAN+3 steps
// NORM  | normalise, classify specials, register the result
// DONE  | o_valid pulse, result visible
module div_flotante_seq #(
    parameter int NB_EXP = 4,
    parameter int NB_MAN = 8,
    parameter int BIAS   = 7
) (
    input  logic               i_clock,
    input  logic               i_reset,
    div_flotante_seq_if.slave  bus
);
    localparam int NB_FLT = 1 + NB_EXP + NB_MAN;
    localparam int NB_Q   = NB_MAN + 3;        // quotient bits
    localparam int RW     = NB_MAN + 2;        // partial remainder width
    localparam int EW     = NB_EXP + 2;        // signed working exponent
    localparam int CW     = $clog2(NB_Q);
    localparam int E_MAX  = (1 << NB_EXP) - 1;

    localparam logic [CW-1:0]        CNT_LOAD = CW'(NB_Q - 1);
    localparam logic signed [EW-1:0] BIAS_E   = EW'(BIAS);
    localparam logic signed [EW-1:0] ONE_E    = EW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        NORM = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state, state_next;

    logic ready;
    logic valid;
    logic accept;

    // operand fields
    logic              s1, s2;
    logic [NB_EXP-1:0] e1, e2;
    logic [NB_MAN-1:0] m1, m2;

    // working registers
    logic                 sign_r;
    logic                 z1_r, z2_r;
    logic signed [EW-1:0] e_acc;
    logic [RW-1:0]        rem;
    logic [RW-1:0]        dvsr;
    logic [NB_Q-1:0]      q;
    logic [CW-1:0]        cnt;

    // output registers
    logic [NB_FLT-1:0] cociente_r;
    logic              div_cero_r;
    logic              desborde_r;

    // division step
    logic [RW:0]   diff;
    logic          borrow;
    logic [RW-1:0] rem_sel;

    // normalisation / result
    logic signed [EW-1:0] e_norm;
    logic signed [EW-1:0] e_fin;
    logic [NB_MAN-1:0]    man_norm;
    logic [NB_MAN-1:0]    man_fin;
    logic [NB_FLT-1:0]    res_cociente;
    logic                 res_div_cero;
    logic                 res_desborde;
`ifdef DIV_FLOTANTE_REDONDEO_EN
    logic                 guard;
    logic [NB_MAN:0]      man_sum;
`endif

    assign s1 = bus.i_flotante_1[NB_FLT-1];
    assign e1 = bus.i_flotante_1[NB_FLT-2 -: NB_EXP];
    assign m1 = bus.i_flotante_1[NB_MAN-1:0];
    assign s2 = bus.i_flotante_2[NB_FLT-1];
    assign e2 = bus.i_flotante_2[NB_FLT-2 -: NB_EXP];
    assign m2 = bus.i_flotante_2[NB_MAN-1:0];

    // ---------------- FSM ----------------
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        ready      = 1'b0;
        valid      = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (bus.i_valid) begin
                    state_next = CALC;
                end
            end
            CALC: begin
                if (cnt == '0) begin
                    state_next = NORM;
                end
            end
            NORM: begin
                state_next = DONE;
            end
            DONE: begin
                valid      = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign accept = ready & bus.i_valid;

    // ---------------- division step ----------------
    // Partial remainder stays below 2*divisor, so RW bits are enough after
    // the shift; the extra diff bit is the borrow.
    always_comb begin
        diff    = {1'b0, rem} - {1'b0, dvsr};
        borrow  = diff[RW];
        rem_sel = borrow ? rem : diff[RW-1:0];
    end

    // ---------------- normalisation ----------------
    always_comb begin
        if (q[NB_Q-1]) begin
            man_norm = q[NB_Q-2:2];
            e_norm   = e_acc;
        end else begin
            man_norm = q[NB_Q-3:1];
            e_norm   = e_acc - ONE_E;
        end

`ifdef DIV_FLOTANTE_REDONDEO_EN
        guard   = q[NB_Q-1] ? q[1] : q[0];
        man_sum = {1'b0, man_norm} + {{NB_MAN{1'b0}}, guard};
        if (man_sum[NB_MAN]) begin
            // mantissa wrapped to 1.0 -> next binade
            man_fin = '0;
            e_fin   = e_norm + ONE_E;
        end else begin
            man_fin = man_sum[NB_MAN-1:0];
            e_fin   = e_norm;
        end
`else
        man_fin = man_norm;
        e_fin   = e_norm;
`endif

        res_div_cero = 1'b0;
        res_desborde = 1'b0;
        if (z2_r) begin
            res_cociente = {sign_r, {NB_EXP{1'b1}}, {NB_MAN{1'b1}}};
            res_div_cero = 1'b1;
        end else if (z1_r) begin
            res_cociente = {sign_r, {(NB_FLT-1){1'b0}}};
        end else if (int'(e_fin) > E_MAX) begin
            res_cociente = {sign_r, {NB_EXP{1'b1}}, {NB_MAN{1'b1}}};
            res_desborde = 1'b1;
        end else if (int'(e_fin) < 1) begin
            res_cociente = {sign_r, {(NB_FLT-1){1'b0}}};
        end else begin
            res_cociente = {sign_r, e_fin[NB_EXP-1:0], man_fin};
        end
    end

    // ---------------- datapath ----------------
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            sign_r     <= 1'b0;
            z1_r       <= 1'b0;
            z2_r       <= 1'b0;
            e_acc      <= '0;
            rem        <= '0;
            dvsr       <= '0;
            q          <= '0;
            cnt        <= '0;
            cociente_r <= '0;
            div_cero_r <= 1'b0;
            desborde_r <= 1'b0;
        end else begin
            if (accept) begin
                sign_r <= s1 ^ s2;
                z1_r   <= (e1 == '0);
                z2_r   <= (e2 == '0);
                e_acc  <= $signed({2'b00, e1}) - $signed({2'b00, e2}) + BIAS_E;
                rem    <= {1'b0, 1'b1, m1};
                dvsr   <= {1'b0, 1'b1, m2};
                q      <= '0;
                cnt    <= CNT_LOAD;
            end

            if (state == CALC) begin
                q   <= {q[NB_Q-2:0], ~borrow};
                rem <= rem_sel << 1;
                if (cnt != '0) begin
                    cnt <= cnt - 1'b1;
                end
            end

            if (state == NORM) begin
                cociente_r <= res_cociente;
                div_cero_r <= res_div_cero;
                desborde_r <= res_desborde;
            end
        end
    end

    assign bus.o_ready    = ready;
    assign bus.o_valid    = valid;
    assign bus.o_cociente = cociente_r;
    assign bus.o_div_cero = div_cero_r;
    assign bus.o_desborde = desborde_r;

endmodule

// File: tb/tb_div_flotante_seq.sv
// Directed bench for div_flotante_seq: hand-computed quotients, latency,
// special cases, mid-operation reset and the busy-period handshake.
module tb_div_flotante_seq;
    localparam int NB_EXP = 4;
    localparam int NB_MAN = 8;
    localparam int LAT    = NB_MAN + 4;

    logic clk;
    logic rst;

    div_flotante_seq_if #(.NB_EXP(NB_EXP), .NB_MAN(NB_MAN)) bus ();

    div_flotante_seq #(.NB_EXP(NB_EXP), .NB_MAN(NB_MAN), .BIAS(7)) dut (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Waits for o_valid after an accept edge that just happened; returns
    // the number of rising edges counted (0 on timeout).
    task automatic wait_result(output int cyc);
        cyc = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (bus.o_valid === 1'b1) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic do_div(input string tag, input logic [12:0] a, input logic [12:0] b,
                          input logic [12:0] exp_q, input logic exp_dz, input logic exp_ov);
        int cyc;
        @(negedge clk);
        chk({tag, "_ready"}, 32'(bus.o_ready), 32'd1);
        bus.i_valid      = 1'b1;
        bus.i_flotante_1 = a;
        bus.i_flotante_2 = b;
        @(posedge clk); #1;
        bus.i_valid      = 1'b0;
        bus.i_flotante_1 = '0;
        bus.i_flotante_2 = '0;
        wait_result(cyc);
        chk({tag, "_lat"}, 32'(cyc), 32'(LAT));
        chk({tag, "_q"},   32'(bus.o_cociente), 32'(exp_q));
        chk({tag, "_dz"},  32'(bus.o_div_cero), 32'(exp_dz));
        chk({tag, "_ov"},  32'(bus.o_desborde), 32'(exp_ov));
        @(posedge clk); #1;
        chk({tag, "_vpulse"}, 32'(bus.o_valid), 32'd0);
        chk({tag, "_hold"},   32'(bus.o_cociente), 32'(exp_q));
    endtask

    int cyc;
    int n_valid;
    logic [12:0] exp_round;

    initial begin
        rst              = 1'b1;
        bus.i_valid      = 1'b0;
        bus.i_flotante_1 = '0;
        bus.i_flotante_2 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        chk("rst_ready", 32'(bus.o_ready),    32'd1);
        chk("rst_valid", 32'(bus.o_valid),    32'd0);
        chk("rst_q",     32'(bus.o_cociente), 32'd0);
        chk("rst_dz",    32'(bus.o_div_cero), 32'd0);
        chk("rst_ov",    32'(bus.o_desborde), 32'd0);

        // 35.625 / -18.6875 = -1.90625 (truncated)
        do_div("t1", 13'b0_1100_00011101, 13'b1_1011_00101011, 13'b1_0111_11101000, 1'b0, 1'b0);
        // 1/1
        do_div("t2a", 13'b0_0111_00000000, 13'b0_0111_00000000, 13'b0_0111_00000000, 1'b0, 1'b0);
        // 1/1.25 = 0.8: q=819, guard=1
`ifdef DIV_FLOTANTE_REDONDEO_EN
        exp_round = 13'b0_0110_10011010;
`else
        exp_round = 13'b0_0110_10011001;
`endif
        do_div("t2b", 13'b0_0111_00000000, 13'b0_0111_01000000, exp_round, 1'b0, 1'b0);
        // sign of the divided result with negative dividend: -1 / 1.25
`ifdef DIV_FLOTANTE_REDONDEO_EN
        exp_round = 13'b1_0110_10011010;
`else
        exp_round = 13'b1_0110_10011001;
`endif
        do_div("t2c", 13'b1_0111_00000000, 13'b0_0111_01000000, exp_round, 1'b0, 1'b0);
        // overflow clears division-by-zero flag and vice versa
        do_div("t4a", 13'b0_1111_00000000, 13'b0_0001_00000000, 13'b0_1111_11111111, 1'b0, 1'b1);
        do_div("t3a", 13'b0_1100_00011101, 13'b0,               13'b0_1111_11111111, 1'b1, 1'b0);
        do_div("t3b", 13'b0,               13'b0_1100_00011101, 13'b0_0000_00000000, 1'b0, 1'b0);
        do_div("t4b", 13'b0_0001_00000000, 13'b0_1111_00000000, 13'b0_0000_00000000, 1'b0, 1'b0);
        // divide by zero with negative sign, top exponent result e=15 exactly stays normal
        do_div("t3c", 13'b1_0011_00000000, 13'b0, 13'b1_1111_11111111, 1'b1, 1'b0);
        do_div("t4c", 13'b0_1111_00000000, 13'b0_0111_00000000, 13'b0_1111_00000000, 1'b0, 1'b0);

        // ---- reset 5 cycles after accept, with nonzero result/flag held ----
        @(negedge clk);
        bus.i_valid      = 1'b1;
        bus.i_flotante_1 = 13'b0_0111_00000000;
        bus.i_flotante_2 = 13'b0;
        @(posedge clk); #1;
        bus.i_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("t5_ready", 32'(bus.o_ready),    32'd1);
        chk("t5_valid", 32'(bus.o_valid),    32'd0);
        n_valid = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (bus.o_valid === 1'b1) n_valid++;
        end
        chk("t5_novalid", 32'(n_valid),        32'd0);
        chk("t5_q",       32'(bus.o_cociente), 32'd0);
        chk("t5_dz",      32'(bus.o_div_cero), 32'd0);
        chk("t5_ov",      32'(bus.o_desborde), 32'd0);

        // ---- i_valid held high across busy period ----
        @(negedge clk);
        bus.i_valid      = 1'b1;
        bus.i_flotante_1 = 13'b0_1100_00011101;
        bus.i_flotante_2 = 13'b1_1011_00101011;
        @(posedge clk); #1;
        cyc = 0;
        for (int i = 1; i <= 40; i++) begin
            // junk operands while busy; alternating divisor zero / overflow
            bus.i_flotante_1 = (i % 2 == 0) ? 13'b0_1111_00000000 : 13'b1_0010_10101010;
            bus.i_flotante_2 = (i % 2 == 0) ? 13'b0               : 13'b0_0001_00000000;
            @(posedge clk); #1;
            if (bus.o_valid === 1'b1) begin
                cyc = i;
                break;
            end
        end
        chk("t6_lat",   32'(cyc),              32'(LAT));
        chk("t6_q",     32'(bus.o_cociente),   32'(13'b1_0111_11101000));
        chk("t6_dz",    32'(bus.o_div_cero),   32'd0);
        chk("t6_ready_done", 32'(bus.o_ready), 32'd0);
        @(negedge clk);
        bus.i_flotante_1 = 13'b0_0111_00000000;
        bus.i_flotante_2 = 13'b0_0111_00000000;
        @(posedge clk); #1;
        chk("t6_ready_idle", 32'(bus.o_ready), 32'd1);
        @(posedge clk); #1;
        bus.i_valid = 1'b0;
        wait_result(cyc);
        chk("t6b_lat", 32'(cyc),            32'(LAT));
        chk("t6b_q",   32'(bus.o_cociente), 32'(13'b0_0111_00000000));

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
